// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg: shared types and default sizes for the APB scratch memory slave
package apb_mem_pkg;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} apb_state_t;
endpackage

// File: rtl/apb_mem_if.sv
// apb_mem_if: APB bus bundle between a master and the memory slave
interface apb_mem_if
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
  logic                  psel_i;
  logic                  penable_i;
  logic [ADDR_WIDTH-1:0] paddr_i;
  logic                  pwrite_i;
  logic [DATA_WIDTH-1:0] pwdata_i;
  logic [DATA_WIDTH-1:0] prdata_o;
  logic                  pready_o;
  modport master (output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, input prdata_o, pready_o);
  modport slave  (input psel_i, penable_i, paddr_i, pwrite_i, pwdata_i, output prdata_o, pready_o);
endinterface

// File: rtl/apb_mem_slave_simple_mem.sv
// simple_mem: single-port RAM with registered read; only the read register is reset
module simple_mem
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  always_ff @(posedge clk)
    if (wr_en_i) r_mem[addr_i] <= wdata_i;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_rdata <= '0;
    else if (rd_en_i) r_rdata <= r_mem[addr_i];
  assign rdata_o = r_rdata;
endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: zero-wait-state APB slave fronting a word-addressed RAM
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic       clk,
  input logic       reset,
  apb_mem_if.slave  bus
);
  apb_state_t            current_state, next_state;
  logic                  w_rd_en, w_wr_en;
  logic [DATA_WIDTH-1:0] w_rdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) current_state <= IDLE;
    else current_state <= next_state;
  always_comb begin
    next_state = IDLE;
    if (current_state == IDLE && bus.psel_i && !bus.penable_i) next_state = ACCESS;
  end
  // read is launched at the end of setup so data is ready for the access cycle
  assign w_rd_en = (current_state == IDLE) && bus.psel_i && !bus.penable_i && !bus.pwrite_i;
  assign w_wr_en = (current_state == ACCESS) && bus.psel_i && bus.penable_i && bus.pwrite_i;
  simple_mem #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en_i (w_wr_en),
    .rd_en_i (w_rd_en),
    .addr_i  (bus.paddr_i),
    .wdata_i (bus.pwdata_i),
    .rdata_o (w_rdata)
  );
  assign bus.pready_o = current_state == ACCESS;
  assign bus.prdata_o = (current_state == ACCESS && !bus.pwrite_i) ? w_rdata : '0;
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: randomized APB transfers checked against an array model of the memory
module tb_apb_mem_slave;
  import apb_mem_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  logic [31:0] model_mem [1024];
  logic [9:0]  known_q [$];
  apb_mem_if bus ();
  apb_mem_slave dut (.clk(clk), .reset(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic bus_idle();
    @(negedge clk);
    bus.psel_i = 1'b0;
    bus.penable_i = 1'b0;
    #1;
    chk("idle_pready", {31'b0, bus.pready_o}, 32'd0);
  endtask
  task automatic apb_write(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b1; bus.paddr_i = a; bus.pwdata_i = d;
    #1;
    chk("wr_setup_pready", {31'b0, bus.pready_o}, 32'd0);
    @(negedge clk);
    bus.penable_i = 1'b1;
    #1;
    chk("wr_access_pready", {31'b0, bus.pready_o}, 32'd1);
    chk("wr_access_state", {31'b0, dut.current_state}, {31'b0, ACCESS});
    chk("wr_access_prdata", bus.prdata_o, 32'd0);
    bus_idle();
    if (!(a inside {known_q})) known_q.push_back(a);
    model_mem[a] = d;
  endtask
  task automatic apb_read(input logic [9:0] a);
    @(negedge clk);
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0; bus.paddr_i = a;
    bus.pwdata_i = $urandom;
    #1;
    chk("rd_setup_pready", {31'b0, bus.pready_o}, 32'd0);
    chk("rd_setup_prdata", bus.prdata_o, 32'd0);
    @(negedge clk);
    bus.penable_i = 1'b1;
    #1;
    chk("rd_access_pready", {31'b0, bus.pready_o}, 32'd1);
    chk($sformatf("rd_data_%03h", a), bus.prdata_o, model_mem[a]);
    bus_idle();
  endtask
  initial begin
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0; bus.paddr_i = '0; bus.pwdata_i = '0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_pready", {31'b0, bus.pready_o}, 32'd0);
      chk("rst_prdata", bus.prdata_o, 32'd0);
      chk("rst_state", {31'b0, dut.current_state}, {31'b0, IDLE});
    end
    rst_n = 1'b1;
    apb_write(10'h010, 32'hDEADBEEF);
    apb_read(10'h010);
    apb_write(10'h020, 32'hF00DF00D);
    apb_read(10'h020);
    apb_read(10'h010);
    apb_write(10'h000, 32'h11111111);
    apb_write(10'h3FF, 32'h22222222);
    apb_read(10'h000);
    apb_read(10'h3FF);
    apb_write(10'h040, 32'h55555555);
    @(negedge clk);
    bus.psel_i = 1'b1; bus.penable_i = 1'b1; bus.pwrite_i = 1'b1; bus.paddr_i = 10'h040; bus.pwdata_i = 32'hBAD;
    #1;
    chk("viol_pready0", {31'b0, bus.pready_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("viol_pready1", {31'b0, bus.pready_o}, 32'd0);
    chk("viol_state", {31'b0, dut.current_state}, {31'b0, IDLE});
    bus_idle();
    apb_read(10'h040);
    apb_write(10'h030, 32'hAAAAAAAA);
    @(negedge clk);
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b1; bus.paddr_i = 10'h030; bus.pwdata_i = 32'h12345678;
    @(negedge clk);
    bus.penable_i = 1'b1;
    #1;
    chk("abort_pre_pready", {31'b0, bus.pready_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_pready", {31'b0, bus.pready_o}, 32'd0);
    chk("abort_prdata", bus.prdata_o, 32'd0);
    chk("abort_state", {31'b0, dut.current_state}, {31'b0, IDLE});
    repeat (2) @(negedge clk);
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    rst_n = 1'b1;
    apb_read(10'h030);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1) == 1) apb_read(known_q[$urandom_range(known_q.size() - 1)]);
      else apb_write(10'($urandom_range(1023)), $urandom);
    end
    foreach (known_q[i]) apb_read(known_q[i]);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- APB (v2-style, PSEL/PENABLE/PREADY) slave that fronts a single-port word-addressed RAM.
- Zero-wait-state transfers: each transfer is one SETUP cycle plus one ACCESS cycle.
- Sits on the peripheral bus as a scratch/register memory; no PSLVERR, no byte strobes.

Parameters:
- ADDR_WIDTH, 10: word address width; RAM depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: data word width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- psel_i  input  1  APB select
- penable_i  input  1  APB enable (access phase)
- paddr_i  input  ADDR_WIDTH  word address, no byte offset bits
- pwrite_i  input  1  1 = write, 0 = read
- pwdata_i  input  DATA_WIDTH  write data
- prdata_o  output  DATA_WIDTH  read data
- pready_o  output  1  transfer-complete indication

Behaviour:
- FSM registers are named current_state and next_state, of enum type apb_state_t with states IDLE and ACCESS; next_state is combinational.
- IDLE -> ACCESS: on a clock edge where psel_i=1 and penable_i=0 (setup phase sampled).
- IDLE stays IDLE otherwise, including psel_i=1 with penable_i=1. A protocol violation is ignored, with no memory side effect.
- ACCESS -> IDLE: unconditionally on the next edge. The transfer completes on that edge if psel_i=1 and penable_i=1.
- pready_o = 1 exactly when current_state==ACCESS; it is registered-state decoded, so it is high for the whole access cycle.
- Read path:
  - mem rd_en = (current_state==IDLE) & psel_i & ~penable_i & ~pwrite_i.
  - The RAM registers mem[paddr_i] into its read register at that edge, i.e. at the end of setup.
  - prdata_o = RAM read register when current_state==ACCESS and pwrite_i==0, else 0.
- Write path:
  - mem wr_en = (current_state==ACCESS) & psel_i & penable_i & pwrite_i.
  - The RAM commits pwdata_i to mem[paddr_i] at the edge ending ACCESS.
  - Data is readable by any later transfer.
- Address is used directly as word index; all 2**ADDR_WIDTH locations are valid, with no wrap or decode error.
- Reset (asynchronous, active-low):
  - current_state=IDLE, pready_o=0, prdata_o=0, RAM read register=0.
  - RAM array contents are not reset (X until written).
  - Reset during ACCESS aborts the transfer, so a pending write is not committed.
- Back-to-back transfers: a new setup is accepted only from IDLE. The master must return psel_i or penable_i low for at least one cycle, per the APB idle/setup sequence.
- Latency: a read returns data and pready_o in the first access cycle. A write is visible from the cycle after ACCESS.

Decomposition:
- Package apb_mem_pkg holds:
  - the apb_state_t enum (IDLE, ACCESS);
  - default ADDR_WIDTH/DATA_WIDTH constants.
- One sub-module, simple_mem: synchronous single-port RAM.
  - Ports: clk, reset, wr_en_i, rd_en_i, addr_i, wdata_i, rdata_o.
  - Write on wr_en_i. Registered read on rd_en_i, otherwise the read register holds its value; read register reset to 0.
- The APB FSM and strobe decode live in apb_mem_slave.

Test Plan:
- Reset held 5 cycles then released -> pready_o=0, prdata_o=0, current_state=IDLE throughout reset.
- Write 0xDEADBEEF to 0x010 (setup, then access) -> pready_o=1 in access cycle, state IDLE->ACCESS->IDLE; then read 0x010 -> pready_o=1 and prdata_o=0xDEADBEEF in access cycle.
- Write 0xF00DF00D to 0x020, read 0x020 -> 0xF00DF00D; reread 0x010 -> still 0xDEADBEEF.
- Boundary addresses: write 0x11111111 to 0x000 and 0x22222222 to 0x3FF, read back both -> exact values, no aliasing.
- Protocol violation: psel_i=1, penable_i=1 from IDLE with pwrite_i=1, data 0xBAD -> state stays IDLE, pready_o=0, target location unchanged on later read.
- Reset asserted mid-ACCESS of a write of 0x12345678 to 0x030 (prior value 0xAAAAAAAA) -> outputs return to 0 immediately, later read of 0x030 returns 0xAAAAAAAA.
